cpu_slot_arbiter: RTL and testbench
===================================

Name: cpu_slot_arbiter

Overview:
- Parametrised time-slot bus arbiter that shares one I/O device bus among NCPU CPU cores.
- Successor to the fixed 3-CPU rotating-slot arbiter. Generalised in CPU count, slot count, slot length and bus widths.
- Drives per-CPU clock-enables (not derived clocks). Registers read data per CPU and supports per-CPU HOLD (pause).
- Sits between the CPU cores and the device decode/memory block, in the MCLK domain.

Parameters:
- NCPU, 3, number of CPU ports (1..8).
- NSLOT, 4, slots per rotation; must be >= NCPU. Slots NCPU..NSLOT-1 are idle.
- SLOTLEN, 4, MCLK cycles per slot; must be >= 2.
- AW, 16, address width.
- DW, 8, data width.

Ports:
- MCLK  in  1  system clock (48 MHz)
- RESET_N  in  1  asynchronous active-low reset
- HOLD  in  NCPU  per-CPU pause request
- CPU_AD  in  NCPU*AW  flattened CPU addresses; CPU i occupies bits [i*AW +: AW]
- CPU_RD  in  NCPU  read strobes
- CPU_WR  in  NCPU  write strobes
- CPU_DO  in  NCPU*DW  CPU write data
- CPU_CE  out  NCPU  one-MCLK clock-enable pulse per CPU
- CPU_DV  out  NCPU  registered device-valid per CPU
- CPU_DI  out  NCPU*DW  registered read data per CPU
- DEV_AD  out  AW  device address
- DEV_RD  out  1  device read
- DEV_WR  out  1  device write
- DEV_DI  out  DW  device write data
- DEV_DV  in  1  device data valid
- DEV_DO  in  DW  device read data
- SLOT  out  3  current slot index, for debug

Behaviour:
- Clock and reset: one clock (MCLK). Reset is asynchronous, active-low (RESET_N).
- State:
  - SCNT counts 0..SLOTLEN-1.
  - SIDX counts 0..NSLOT-1.
  - SCNT wraps to 0 on SLOTLEN-1, and SIDX increments at the same time. SIDX wraps NSLOT-1 -> 0.
- Reset values: SCNT=0, SIDX=0, CPU_CE=0, CPU_DV=0, CPU_DI=0.
  - DEV_* are combinational from state, so they show CPU0's bus immediately.
  - Reset mid-slot aborts the slot; no CE is issued.
- Ownership:
  - Slot s < NCPU is owned by CPU s, unless HOLD[s] was sampled high at SCNT==0 (latched for the whole slot).
  - DEV_AD/RD/WR/DI mux the owner's signals. Idle or held slots drive all zeros.
- CPU_CE[i]: asserted exactly one cycle, when SIDX==i, SCNT==SLOTLEN-1 and the slot is not held.
  - First CE after reset release goes to CPU0, at MCLK cycle SLOTLEN-1.
  - Period per CPU is NSLOT*SLOTLEN cycles (16 by default, giving 3 MHz).
- Read capture: on the CE cycle, CPU_DI[i] <= DEV_DO and CPU_DV[i] <= DEV_DV. Both hold until CPU i's next CE.
  - Other CPUs' outputs never change outside their own slot.
- HOLD changing mid-slot has no effect until the next SCNT==0.
- Idle-slot count is NSLOT-NCPU. With NSLOT==NCPU there are no idle slots.
- SLOT = SIDX, zero-extended or truncated to 3 bits.

Optional Feature:
- Macro: ARB_HOLDSKIP_EN.
- Defined:
  - A slot whose owner is held at SCNT==0 lasts 1 MCLK instead of SLOTLEN, raising the other CPUs' rate.
  - Idle slots are never shortened.
  - If all CPUs are held, rotation continues with 1-cycle CPU slots and full-length idle slots.
- Undefined: held slots run the full SLOTLEN, with bus zeroed and no CE. The rate of the other CPUs is unchanged.

Decomposition:
- Shared package cpu_arb_pkg:
  - localparam function clog2.
  - Slot-state typedef {SIDX, SCNT}.
  - Default constants: NCPU_DEF=3, NSLOT_DEF=4, SLOTLEN_DEF=4.
- One sub-module: arb_slot_timer. It owns SCNT/SIDX, the hold latch and skip logic, and emits slot_idx, slot_last and slot_held.
- The top level does the muxing and per-CPU capture registers.

Test Plan:
- Reset release, defaults, all CPUs active: CPU_CE[0] at cycle 3, CPU_CE[1] at 7, CPU_CE[2] at 11, none at 15; repeats every 16. DEV_* are zero during cycles 12-15.
- CPU1 presents AD=16'h6800, RD=1, and the device returns DV=1, DO=8'hA5: CPU_DI[1]=8'hA5 and CPU_DV[1]=1 the cycle after CE[1], stable for 16 cycles. CPU_DI[0] and CPU_DI[2] remain unchanged.
- CPU2 writes AD=16'h9000, DO=8'h3C, WR=1: DEV_WR=1, DEV_AD=16'h9000, DEV_DI=8'h3C for exactly cycles 8-11 of the rotation.
- HOLD[0] raised at cycle 2 of slot 0: that slot still completes with CE[0]. The next slot 0 is zero-bus with no CE. Without ARB_HOLDSKIP_EN, CE[1] still lands at rotation cycle 7.
- With ARB_HOLDSKIP_EN and HOLD[0]=1 constant: slot 0 lasts 1 cycle, giving a rotation of 13 cycles. CE[1] follows CE[1] after 13 cycles.
- RESET_N pulsed low mid-slot 1 at SCNT=2: no CE is issued, all CPU_DV/CPU_DI clear, and the sequence restarts with CE[0] at cycle 3 after release.

Source files
------------

// File: rtl/cpu_arb_pkg.sv
// cpu_arb_pkg: shared defaults, slot-state type and helpers for cpu_slot_arbiter.
// Slot counters are kept 8 bits wide, so NSLOT and SLOTLEN may each go up to 256.
package cpu_arb_pkg;
   localparam int NCPU_DEF    = 3;
   localparam int NSLOT_DEF   = 4;
   localparam int SLOTLEN_DEF = 4;
   localparam int SW          = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

   typedef struct packed {
      logic [SW-1:0] sidx;
      logic [SW-1:0] scnt;
   } slot_t;
endpackage

// File: rtl/arb_slot_timer.sv
// arb_slot_timer: slot rotation counters with per-slot hold latch.
// With ARB_HOLDSKIP_EN defined, a held CPU slot collapses to a single cycle.
import cpu_arb_pkg::*;

module arb_slot_timer #(
   parameter int NCPU    = NCPU_DEF,
   parameter int NSLOT   = NSLOT_DEF,
   parameter int SLOTLEN = SLOTLEN_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [NCPU-1:0] hold,
   output logic [SW-1:0] slot_idx,
   output logic          slot_last,
   output logic          slot_held
);
   slot_t st_q, st_d;
   logic  held_q, held_d, held_now;

   always_comb begin
      held_now = 1'b0;
      for (int i = 0; i < NCPU; i++)
         if (st_q.sidx == SW'(i)) held_now = hold[i];
      // hold is only sampled on the first cycle of a slot, then latched
      slot_held = (st_q.scnt == '0) ? held_now : held_q;
`ifdef ARB_HOLDSKIP_EN
      slot_last = slot_held || (st_q.scnt == SW'(SLOTLEN - 1));
`else
      slot_last = st_q.scnt == SW'(SLOTLEN - 1);
`endif
      held_d    = slot_held;
      st_d.scnt = slot_last ? '0 : st_q.scnt + 1'b1;
      st_d.sidx = !slot_last ? st_q.sidx :
                  (st_q.sidx == SW'(NSLOT - 1)) ? '0 : st_q.sidx + 1'b1;
   end

   assign slot_idx = st_q.sidx;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st_q   <= '0;
         held_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         held_q <= held_d;
      end
endmodule

// File: rtl/cpu_slot_arbiter.sv
// cpu_slot_arbiter: time-slot arbiter sharing one device bus among NCPU cores.
// Optional ARB_HOLDSKIP_EN shortens held slots to one MCLK (see arb_slot_timer).
import cpu_arb_pkg::*;

module cpu_slot_arbiter #(
   parameter int NCPU    = NCPU_DEF,
   parameter int NSLOT   = NSLOT_DEF,
   parameter int SLOTLEN = SLOTLEN_DEF,
   parameter int AW      = 16,
   parameter int DW      = 8
) (
   input  logic               MCLK,
   input  logic               RESET_N,
   input  logic [NCPU-1:0]    HOLD,
   input  logic [NCPU*AW-1:0] CPU_AD,
   input  logic [NCPU-1:0]    CPU_RD,
   input  logic [NCPU-1:0]    CPU_WR,
   input  logic [NCPU*DW-1:0] CPU_DO,
   output logic [NCPU-1:0]    CPU_CE,
   output logic [NCPU-1:0]    CPU_DV,
   output logic [NCPU*DW-1:0] CPU_DI,
   output logic [AW-1:0]      DEV_AD,
   output logic               DEV_RD,
   output logic               DEV_WR,
   output logic [DW-1:0]      DEV_DI,
   input  logic               DEV_DV,
   input  logic [DW-1:0]      DEV_DO,
   output logic [2:0]         SLOT
);
   logic [SW-1:0]      slot_idx;
   logic               slot_last, slot_held;
   logic [NCPU*DW-1:0] di_q, di_d;
   logic [NCPU-1:0]    dv_q, dv_d;

   arb_slot_timer #(.NCPU(NCPU), .NSLOT(NSLOT), .SLOTLEN(SLOTLEN)) u_timer (
      .clk       (MCLK),
      .rst_n     (RESET_N),
      .hold      (HOLD),
      .slot_idx  (slot_idx),
      .slot_last (slot_last),
      .slot_held (slot_held)
   );

   always_comb begin
      CPU_CE = '0;
      DEV_AD = '0;
      DEV_RD = 1'b0;
      DEV_WR = 1'b0;
      DEV_DI = '0;
      di_d   = di_q;
      dv_d   = dv_q;
      for (int i = 0; i < NCPU; i++)
         if (slot_idx == SW'(i) && !slot_held) begin
            CPU_CE[i] = slot_last;
            DEV_AD    = CPU_AD[i*AW +: AW];
            DEV_RD    = CPU_RD[i];
            DEV_WR    = CPU_WR[i];
            DEV_DI    = CPU_DO[i*DW +: DW];
            if (slot_last) begin
               di_d[i*DW +: DW] = DEV_DO;
               dv_d[i]          = DEV_DV;
            end
         end
   end

   always_ff @(posedge MCLK or negedge RESET_N)
      if (!RESET_N) begin
         di_q <= '0;
         dv_q <= '0;
      end else begin
         di_q <= di_d;
         dv_q <= dv_d;
      end

   assign CPU_DI = di_q;
   assign CPU_DV = dv_q;
   assign SLOT   = slot_idx[2:0];
endmodule

// File: tb/tb_cpu_slot_arbiter.sv
// tb_cpu_slot_arbiter: directed bench for cpu_slot_arbiter (defaults NCPU=3, NSLOT=4, SLOTLEN=4).
module tb_cpu_slot_arbiter;
   localparam int NCPU = 3, NSLOT = 4, SLOTLEN = 4;
   logic        MCLK = 1'b0, RESET_N = 1'b0;
   logic [2:0]  HOLD, CPU_RD, CPU_WR, CPU_CE, CPU_DV, SLOT;
   logic [47:0] CPU_AD;
   logic [23:0] CPU_DO, CPU_DI;
   logic [15:0] DEV_AD;
   logic        DEV_RD, DEV_WR, DEV_DV;
   logic [7:0]  DEV_DI, DEV_DO;
   int          n_cmp = 0, n_bad = 0, c, m_idx, m_cnt;
   logic        m_held;
   logic [23:0] e_di;
   logic [2:0]  e_dv;
   logic [15:0] t_ad  [3] = '{16'h1111, 16'h6800, 16'h9000};
   logic [7:0]  t_do  [3] = '{8'h11, 8'h22, 8'h3C};
   logic [7:0]  t_rsp [3] = '{8'h5A, 8'hA5, 8'hC3};
   logic [2:0]  t_rd = 3'b011, t_wr = 3'b100;
`ifdef ARB_HOLDSKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   always #5 MCLK = ~MCLK;

   assign DEV_DO = (DEV_AD == 16'h1111) ? 8'h5A : (DEV_AD == 16'h6800) ? 8'hA5 : 8'hC3;
   assign DEV_DV = DEV_RD;

   cpu_slot_arbiter dut (
      .MCLK(MCLK), .RESET_N(RESET_N), .HOLD(HOLD), .CPU_AD(CPU_AD), .CPU_RD(CPU_RD),
      .CPU_WR(CPU_WR), .CPU_DO(CPU_DO), .CPU_CE(CPU_CE), .CPU_DV(CPU_DV), .CPU_DI(CPU_DI),
      .DEV_AD(DEV_AD), .DEV_RD(DEV_RD), .DEV_WR(DEV_WR), .DEV_DI(DEV_DI), .DEV_DV(DEV_DV),
      .DEV_DO(DEV_DO), .SLOT(SLOT)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @c=%0d: got %h expected %h", tag, c, obs, exp);
      end
   endtask

   task automatic model_reset();
      c = 0; m_idx = 0; m_cnt = 0; m_held = 1'b0; e_di = '0; e_dv = '0;
   endtask

   // check one cycle against the expected slot behaviour, then advance one MCLK
   task automatic step();
      logic own, h, last, act;
      logic [2:0] ce;
      int k;
      own  = m_idx < NCPU;
      h    = (m_cnt == 0) ? (own && HOLD[m_idx]) : m_held;
      last = (m_cnt == SLOTLEN - 1) || (SKIP && h);
      act  = own && !h;
      k    = act ? m_idx : 0;
      ce   = (last && act) ? 3'(1 << m_idx) : 3'b000;
      check("ce",     CPU_CE, ce);
      check("dev_ad", DEV_AD, act ? t_ad[k] : 16'h0);
      check("dev_rd", DEV_RD, act && t_rd[k]);
      check("dev_wr", DEV_WR, act && t_wr[k]);
      check("dev_di", DEV_DI, act ? t_do[k] : 8'h0);
      check("slot",   SLOT,   3'(m_idx));
      check("cpu_di", CPU_DI, e_di);
      check("cpu_dv", CPU_DV, e_dv);
      if (c == 3)  check("ce0_at3",   CPU_CE, 3'b001);
      if (c == 7)  check("ce1_at7",   CPU_CE, 3'b010);
      if (c == 11) check("ce2_at11",  CPU_CE, 3'b100);
      if (c == 15) check("none_at15", CPU_CE, 3'b000);
      if (c == 8)  check("di1_at8",   CPU_DI[15:8], 8'hA5);
      if (c == 48) check("held_bus",  DEV_AD, 16'h0);
`ifdef ARB_HOLDSKIP_EN
      if (c == 52) check("skip_ce1_at52", CPU_CE, 3'b010);
      if (c == 65) check("skip_ce1_at65", CPU_CE, 3'b010);
`else
      if (c == 51) check("held_noce_at51", CPU_CE, 3'b000);
      if (c == 55) check("ce1_at55",       CPU_CE, 3'b010);
`endif
      if (ce != 3'b000) begin
         e_di[m_idx*8 +: 8] = t_rsp[m_idx];
         e_dv[m_idx]        = t_rd[m_idx];
      end
      m_held = h;
      m_cnt  = last ? 0 : m_cnt + 1;
      if (last) m_idx = (m_idx + 1) % NSLOT;
      @(negedge MCLK);
      c++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      CPU_AD = {16'h9000, 16'h6800, 16'h1111};
      CPU_DO = {8'h3C, 8'h22, 8'h11};
      CPU_RD = 3'b011;
      CPU_WR = 3'b100;
      HOLD   = 3'b000;
      c      = 0;
      repeat (2) @(negedge MCLK);
      check("rst_ce",   CPU_CE, 3'b000);
      check("rst_dv",   CPU_DV, 3'b000);
      check("rst_di",   CPU_DI, 24'h0);
      check("rst_slot", SLOT,   3'd0);
      check("rst_bus",  DEV_AD, 16'h1111);
      RESET_N = 1'b1;
      model_reset();
      for (int n = 0; n < 70; n++) begin
         if (c == 34) HOLD = 3'b001;
         step();
      end
      for (int n = 0; n < 40 && !(m_idx == 1 && m_cnt == 2); n++) step();
      check("mid_slot1", SLOT, 3'd1);
      RESET_N = 1'b0;
      HOLD    = 3'b000;
      #1;
      check("arst_ce",   CPU_CE, 3'b000);
      check("arst_dv",   CPU_DV, 3'b000);
      check("arst_di",   CPU_DI, 24'h0);
      check("arst_slot", SLOT,   3'd0);
      repeat (2) @(negedge MCLK);
      check("arst_hold_ce", CPU_CE, 3'b000);
      RESET_N = 1'b1;
      model_reset();
      repeat (20) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
